// File: rtl/ecc_scrub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrub_pkg
// Brief    : Shared types and helpers for the SECDED scrub controller.
// Revision : 1.0 - initial release
// ============================================================================
package ecc_scrub_pkg;

  localparam int CW_W = 16;

  typedef logic [3:0] syndrome_t;

  typedef enum logic [1:0] {
    ECC_CLEAN  = 2'd0,
    ECC_SINGLE = 2'd1,
    ECC_DOUBLE = 2'd2
  } ecc_class_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } scrub_state_e;

  // Hamming syndrome: XOR of the positions of every set bit.
  function automatic syndrome_t calc_syndrome(input logic [CW_W-1:0] word);
    syndrome_t s;
    s = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (word[i]) s = s ^ syndrome_t'(i);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/secded16_classify.sv
`default_nettype none
// ============================================================================
// Module   : secded16_classify
// Brief    : Combinational SECDED classifier and single-bit corrector for one
//            16-bit codeword (bit 0 = overall parity, 1/2/4/8 = Hamming parity).
// Revision : 1.0 - initial release
// ============================================================================
module secded16_classify
  import ecc_scrub_pkg::*;
(
  input  logic [CW_W-1:0] i_word,
  output syndrome_t       o_syndrome,
  output ecc_class_e      o_class,
  output logic [CW_W-1:0] o_corrected
);

  syndrome_t w_syndrome;
  logic      w_parity;

  assign w_syndrome  = calc_syndrome(i_word);
  assign w_parity    = ^i_word;
  assign o_syndrome  = w_syndrome;
  // A zero syndrome with odd parity points at the overall parity bit itself.
  assign o_corrected = i_word ^ (CW_W'(1) << w_syndrome);

  always_comb begin
    o_class = ECC_CLEAN;
    if (w_parity) begin
      o_class = ECC_SINGLE;
    end else if (w_syndrome != '0) begin
      o_class = ECC_DOUBLE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrubber
// Brief    : Background scrub of a SECDED-protected SRAM. Define
//            ECC_SCRUB_WRITEBACK_EN to write corrected words back; otherwise
//            the scrub is detect-only.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_scrubber
  import ecc_scrub_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [CW_W-1:0]  mem_wdata,
  input  logic             mem_gnt,
  input  logic [CW_W-1:0]  mem_rdata,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count,
  output logic             ded_flag,
  output logic [AW-1:0]    ded_addr
);

  scrub_state_e     state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CW_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0] sec_count_q, sec_count_d;
  logic [CNT_W-1:0] ded_count_q, ded_count_d;
  logic             ded_flag_q, ded_flag_d;
  logic [AW-1:0]    ded_addr_q, ded_addr_d;
  logic             mem_req_q, mem_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             advance;

  syndrome_t        syndrome;
  ecc_class_e       cls;
  logic [CW_W-1:0]  corrected;
  logic             unused_cls;

  secded16_classify u_classify (
    .i_word      (word_q),
    .o_syndrome  (syndrome),
    .o_class     (cls),
    .o_corrected (corrected)
  );

`ifdef ECC_SCRUB_WRITEBACK_EN
  logic             mem_we_q, mem_we_d;
  logic [CW_W-1:0]  wdata_q, wdata_d;
  assign unused_cls = ^syndrome;
`else
  assign unused_cls = ^{syndrome, corrected};
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    sec_count_d = sec_count_q;
    ded_count_d = ded_count_q;
    ded_flag_d  = ded_flag_q;
    ded_addr_d  = ded_addr_q;
    advance     = 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
    wdata_d     = wdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_READ;
          addr_d      = '0;
          sec_count_d = '0;
          ded_count_d = '0;
          ded_flag_d  = 1'b0;
        end
      end
      S_READ: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        word_d  = mem_rdata;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        case (cls)
          ECC_SINGLE: begin
            if (~&sec_count_q) sec_count_d = sec_count_q + CNT_W'(1);
`ifdef ECC_SCRUB_WRITEBACK_EN
            wdata_d = corrected;
            state_d = S_WRITE;
`else
            advance = 1'b1;
`endif
          end
          ECC_DOUBLE: begin
            if (~&ded_count_q) ded_count_d = ded_count_q + CNT_W'(1);
            ded_flag_d = 1'b1;
            ded_addr_d = addr_q;
            advance    = 1'b1;
          end
          default: advance = 1'b1;
        endcase
      end
`ifdef ECC_SCRUB_WRITEBACK_EN
      S_WRITE: begin
        if (mem_gnt) advance = 1'b1;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (addr_q == AW'(DEPTH - 1)) begin
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + AW'(1);
        state_d = S_READ;
      end
    end

    // Outputs follow the next state so they are registered alongside it.
    mem_req_d = (state_d == S_READ) || (state_d == S_WRITE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
`ifdef ECC_SCRUB_WRITEBACK_EN
    mem_we_d  = (state_d == S_WRITE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      sec_count_q <= '0;
      ded_count_q <= '0;
      ded_flag_q  <= 1'b0;
      ded_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
      mem_we_q    <= 1'b0;
      wdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      sec_count_q <= sec_count_d;
      ded_count_q <= ded_count_d;
      ded_flag_q  <= ded_flag_d;
      ded_addr_q  <= ded_addr_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ECC_SCRUB_WRITEBACK_EN
      mem_we_q    <= mem_we_d;
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sec_count = sec_count_q;
  assign ded_count = ded_count_q;
  assign ded_flag  = ded_flag_q;
  assign ded_addr  = ded_addr_q;
`ifdef ECC_SCRUB_WRITEBACK_EN
  assign mem_we    = mem_we_q;
  assign mem_wdata = wdata_q;
`else
  assign mem_we    = 1'b0;
  assign mem_wdata = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_scrubber
// Brief    : Self-checking bench for ecc_scrubber against a memory/pass model;
//            honours ECC_SCRUB_WRITEBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_scrubber;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mem_gnt = 1'b0;
  logic [15:0]      mem_rdata = 16'h0;
  logic             mem_req, mem_we, busy, done, ded_flag;
  logic [AW-1:0]    mem_addr, ded_addr;
  logic [15:0]      mem_wdata;
  logic [CNT_W-1:0] sec_count, ded_count;

  ecc_scrubber #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .sec_count(sec_count), .ded_count(ded_count),
    .ded_flag(ded_flag), .ded_addr(ded_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } txn_t;

  logic [15:0]   mem [DEPTH];
  txn_t          exp_q[$];
  int            checks = 0, errors = 0;
  bit            in_pass = 0, prev_pend = 0, rd_due = 0, rst_arm = 0, chk_rst = 0, rand_start = 0;
  int            c0 = 0, exp_done = 0, work = 0, exp_sec = 0, exp_ded = 0;
  int            gnt_mode = 0, stall_addr = -1, stall_left = 0, rst_addr = -1;
  int            rel_done = -1, wr_count = 0;
  logic [AW-1:0] exp_ded_addr = '0, prev_addr = '0, rd_addr = '0, wr_addr_last = '0;
  logic          prev_we = 1'b0;
  logic [15:0]   prev_wdata = 16'h0, wr_data_last = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // 0 clean, 1 single, 2 double, from parity and position-XOR syndrome
  function automatic void classify(input logic [15:0] w, output int cls, output logic [15:0] fixed);
    int s = 0;
    for (int i = 0; i < 16; i++) if (w[i]) s = s ^ i;
    fixed = w;
    if (($countones(w) % 2) == 1) begin
      cls   = 1;
      fixed = w ^ (16'h1 << s);
    end else begin
      cls = (s != 0) ? 2 : 0;
    end
  endfunction

  task automatic body();
    txn_t t;
    if (chk_rst) begin
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_sec", 32'(sec_count), 0);
      chk("rst_ded", 32'(ded_count), 0);
      chk("rst_flag", 32'(ded_flag), 0);
      chk("rst_ded_addr", 32'(ded_addr), 0);
      chk_rst = 0;
      rst     = 1'b0;
    end
    chk("busy", 32'(busy), 32'(in_pass && cyc > c0));
`ifndef ECC_SCRUB_WRITEBACK_EN
    chk("we_tied", 32'(mem_we), 0);
`endif
    if (prev_pend) begin
      chk("hold_req", 32'(mem_req), 1);
      chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
      chk("hold_we", 32'(mem_we), 32'(prev_we));
      chk("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
    end
    chk("done", 32'(done), 32'(in_pass && cyc == exp_done));
    if (in_pass && cyc == exp_done) begin
      rel_done = cyc - c0;
      chk("sec_count", 32'(sec_count), 32'(exp_sec));
      chk("ded_count", 32'(ded_count), 32'(exp_ded));
      chk("ded_flag", 32'(ded_flag), 32'(exp_ded > 0));
      chk("ded_addr", 32'(ded_addr), 32'(exp_ded_addr));
      chk("txn_left", 32'(exp_q.size()), 0);
      in_pass = 0;
    end
    if (rst_arm) begin
      rst = 1'b1; chk_rst = 1; in_pass = 0; rst_arm = 0;
      exp_q.delete(); exp_ded_addr = '0;
    end

    mem_rdata = rd_due ? mem[rd_addr] : 16'($urandom);
    rd_due    = 0;
    case (gnt_mode)
      0: mem_gnt = 1'b1;
      1: mem_gnt = ($urandom_range(0, 3) != 0);
      default: begin
        mem_gnt = 1'b1;
        if (mem_req && !mem_we && int'(mem_addr) == stall_addr && stall_left > 0) begin
          mem_gnt = 1'b0;
          stall_left--;
        end
      end
    endcase
    prev_pend = 0;
    if (!in_pass) begin
      chk("idle_req", 32'(mem_req), 0);
    end else if (mem_req) begin
      if (mem_gnt) begin
        if (exp_q.size() == 0) begin
          chk("extra_access", 32'(mem_req), 0);
        end else begin
          t = exp_q.pop_front();
          chk("acc_we", 32'(mem_we), 32'(t.we));
          chk("acc_addr", 32'(mem_addr), 32'(t.addr));
          if (t.we) chk("acc_wdata", 32'(mem_wdata), 32'(t.data));
        end
        if (!mem_we) begin
          rd_due  = 1;
          rd_addr = mem_addr;
          if (int'(mem_addr) == rst_addr) rst_arm = 1;
        end else begin
          mem[mem_addr] = mem_wdata;
          wr_count++;
          wr_addr_last = mem_addr;
          wr_data_last = mem_wdata;
        end
      end else begin
        exp_done++;
        prev_pend  = 1;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
      end
    end
    start = in_pass && rand_start && cyc > c0 && ($urandom_range(0, 15) == 0);
  endtask

  task automatic run_pass(input int mode, input int rst_a, input bit rs);
    int cls;
    logic [15:0] fx;
    txn_t t;
    gnt_mode = mode; rst_addr = rst_a; rand_start = rs;
    work = 0; exp_sec = 0; exp_ded = 0; wr_count = 0; rel_done = -1;
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) begin
      classify(mem[a], cls, fx);
      t = '{we: 1'b0, addr: AW'(a), data: 16'h0};
      exp_q.push_back(t);
      work += 3;
      if (cls == 1) begin
        exp_sec++;
`ifdef ECC_SCRUB_WRITEBACK_EN
        t = '{we: 1'b1, addr: AW'(a), data: fx};
        exp_q.push_back(t);
        work += 1;
`endif
      end else if (cls == 2) begin
        exp_ded++;
        exp_ded_addr = AW'(a);
      end
    end
    if (exp_sec > SAT) exp_sec = SAT;
    if (exp_ded > SAT) exp_ded = SAT;
    start = 1'b1; c0 = cyc; exp_done = c0 + 1 + work; in_pass = 1;
    for (int k = 0; k < 600 && (in_pass || chk_rst); k++) begin
      @(negedge clk);
      body();
    end
    if (in_pass) begin
      chk("pass_timeout", 1, 0);
      in_pass = 0;
    end
    repeat (3) begin
      @(negedge clk);
      body();
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < DEPTH; a++) mem[a] = 16'h0000;
  endtask

  initial begin
    clear_mem();
    @(negedge clk);
    @(negedge clk);
    chk_rst = 1;
    body();
    @(negedge clk);
    body();

    run_pass(0, -1, 0);
    chk("p_clean_cycles", 32'(rel_done), 25);
    chk("p_clean_writes", 32'(wr_count), 0);
    chk("p_clean_flag", 32'(ded_flag), 0);

    clear_mem(); mem[3] = 16'h0020;
    run_pass(0, -1, 0);
    chk("p_bit5_sec", 32'(sec_count), 1);
`ifdef ECC_SCRUB_WRITEBACK_EN
    chk("p_bit5_cycles", 32'(rel_done), 26);
    chk("p_bit5_writes", 32'(wr_count), 1);
    chk("p_bit5_waddr", 32'(wr_addr_last), 3);
    chk("p_bit5_wdata", 32'(wr_data_last), 0);
`else
    chk("p_bit5_cycles", 32'(rel_done), 25);
    chk("p_bit5_writes", 32'(wr_count), 0);
`endif

    clear_mem(); mem[6] = 16'h0001;
    run_pass(0, -1, 0);
    chk("p_bit0_sec", 32'(sec_count), 1);
`ifdef ECC_SCRUB_WRITEBACK_EN
    chk("p_bit0_waddr", 32'(wr_addr_last), 6);
    chk("p_bit0_wdata", 32'(wr_data_last), 0);
`endif

    clear_mem(); mem[2] = 16'h0003;
    run_pass(0, -1, 0);
    chk("p_ded_count", 32'(ded_count), 1);
    chk("p_ded_flag", 32'(ded_flag), 1);
    chk("p_ded_addr", 32'(ded_addr), 2);
    chk("p_ded_writes", 32'(wr_count), 0);

    clear_mem(); stall_addr = 1; stall_left = 4;
    run_pass(2, -1, 0);
    chk("p_stall_cycles", 32'(rel_done), 29);
    chk("p_stall_flag_cleared", 32'(ded_flag), 0);
    stall_addr = -1;

    clear_mem(); mem[4] = 16'h0020;
    run_pass(0, 4, 0);
    chk("p_rst_no_done", 32'(rel_done), 32'(-1));
    chk("p_rst_writes", 32'(wr_count), 0);

    for (int p = 0; p < 10; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        case ($urandom_range(0, 4))
          0: mem[a] = 16'h0000;
          1: mem[a] = 16'hFFFF;
          2: mem[a] = 16'h1 << $urandom_range(0, 15);
          default: mem[a] = 16'($urandom);
        endcase
      end
      run_pass(1, -1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ecc_scrubber.md
# ecc_scrubber

Background scrub controller for a single-port SRAM holding 16-bit SECDED Hamming codewords. On `start` it walks every address once, reads the codeword, and classifies it as clean, single-error or double-error. Single errors are corrected and written back; double errors are counted and flagged. It sits between the ECC-protected memory and a memory-port arbiter, which may stall it with `mem_gnt`.

## Interface
- `DEPTH`, 256, number of codeword addresses scrubbed per pass (≥2)
- `AW`, `$clog2(DEPTH)`, address width (derived, not overridden)
- `CNT_W`, 8, width of the error counters
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous and active-high
- `start`  in  1  begin one pass; ignored while `busy`
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  1 = write, 0 = read; valid with `mem_req`
- `mem_addr`  out  AW  access address
- `mem_wdata`  out  16  corrected codeword (writes only)
- `mem_gnt`  in  1  access accepted this cycle when `mem_req`=1
- `mem_rdata`  in  16  read data; valid exactly one cycle after a granted read
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse at end of pass
- `sec_count`  out  CNT_W  single errors found this pass, saturating
- `ded_count`  out  CNT_W  double errors found this pass, saturating
- `ded_flag`  out  1  sticky; set on any double error; cleared by `rst` or `start`
- `ded_addr`  out  AW  address of most recent double error

## Operation
- Codeword layout:
  - bit 0 is overall parity.
  - Bits 1, 2, 4 and 8 are Hamming parity.
  - The remaining bits are data.
- Classification of registered word `w`:
  - `s` = XOR of the indices `i` (4-bit) for every `w[i]`=1.
  - `p` = `^w`.
  - `p`=0, `s`=0: clean.
  - `p`=1: single error at bit `s` (`s`=0 means bit 0). Corrected word = `w` with bit `s` inverted.
  - `p`=0, `s`≠0: double error. No correction.
- FSM states:
  - IDLE: `start` → clear counters, `ded_flag` and address; go to READ.
  - READ: `mem_req`=1, `mem_we`=0, `mem_addr`=addr. On `mem_gnt` → WAIT; otherwise hold.
  - WAIT: register `mem_rdata` and its classification; go to CHECK.
  - CHECK:
    - Single: increment `sec_count` and go to WRITE.
    - Double: increment `ded_count`, set `ded_flag`, set `ded_addr`=addr, then advance.
    - Clean: advance.
  - WRITE: `mem_req`=1, `mem_we`=1, same addr, `mem_wdata`=corrected word. On `mem_gnt`, advance; otherwise hold.
  - Advance: if addr = `DEPTH-1` → DONE; otherwise addr+1 → READ.
  - DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- Counters saturate at all-ones. They stay readable after the pass until the next `start`.
- `start` while `busy` has no effect.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable while waiting for `mem_gnt`.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, counters=0, `ded_flag`=0, `ded_addr`=0. State = IDLE.
- `rst` mid-pass aborts immediately; the next cycle shows reset values. No partial write is issued after `rst`.
- With `mem_gnt` tied high:
  - A clean or double-error word takes 3 cycles (READ, WAIT, CHECK).
  - A single-error word takes 4 cycles (adds WRITE).
- If `start` is sampled in cycle 0, READ of address 0 is in cycle 1. An all-clean pass pulses `done` in cycle 3·DEPTH+1.
- Each cycle without grant in READ or WRITE adds exactly one cycle.
- `mem_rdata` is sampled only in WAIT.
- Counters and `ded_flag` update at the end of CHECK, visible the following cycle.

## Configuration
- `ECC_SCRUB_WRITEBACK_EN` defined: behaves as above, with the WRITE state and correction path.
- Not defined:
  - Detect-only scrub. The WRITE state and correction logic are absent, and `mem_we` is tied 0.
  - Single errors are still counted; CHECK always advances. `mem_wdata` is tied 0.
  - A clean or single word takes 3 cycles.

## Structure
- Package `ecc_scrub_pkg`:
  - `CW_W`=16.
  - `syndrome_t` (4-bit).
  - enum `ecc_class_e` {ECC_CLEAN, ECC_SINGLE, ECC_DOUBLE}.
  - FSM state enum {S_IDLE, S_READ, S_WAIT, S_CHECK, S_WRITE, S_DONE}.
- One sub-module, `secded16_classify`: combinational; takes the 16-bit word and outputs `syndrome_t`, `ecc_class_e` and the corrected word. It is instantiated once on the WAIT-registered word.

## Test plan
- DEPTH=8, all words 16'h0000, `mem_gnt`=1 → `done` in cycle 25, no writes, `sec_count`=0, `ded_count`=0, `ded_flag`=0.
- Address 3 = 16'h0020 (bit 5 flipped) → one write to address 3 with 16'h0000, `sec_count`=1, `done` in cycle 26.
- Address 6 = 16'h0001 (overall parity bit) → write 16'h0000 to address 6, `sec_count`=1.
- Address 2 = 16'h0003 (`s`=1, `p`=0) → no write, `ded_count`=1, `ded_flag`=1, `ded_addr`=2.
- `mem_gnt` low for 4 cycles on the READ of address 1 → request fields held, `done` 4 cycles later; `rst` asserted in WAIT of address 4 → all outputs at reset values next cycle, no write.
- Without `ECC_SCRUB_WRITEBACK_EN`, address 3 = 16'h0020 → `mem_we` never 1, `sec_count`=1, `done` in cycle 25.
